// File: rtl/fifo_thresh_if.sv
// Producer/consumer bundle for fifo_thresh: push side, pop side, thresholds and status.
// Latency: none, wires only.
// Backpressure: full_o/alm_full_o toward the producer, empty_o/alm_empty_o toward the consumer.
interface fifo_thresh_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
);
  logic                  flush_i;
  logic                  testmode_i;
  logic [CNT_W-1:0]      alm_full_th_i;
  logic [CNT_W-1:0]      alm_empty_th_i;
  logic                  clr_err_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  push_i;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  alm_full_o;
  logic                  alm_empty_o;
  logic [CNT_W-1:0]      usage_o;
  logic                  overflow_o;
  logic                  underflow_o;

  // FIFO side
  modport slave (
    input  flush_i, testmode_i, alm_full_th_i, alm_empty_th_i, clr_err_i,
           data_i, push_i, pop_i,
    output data_o, full_o, empty_o, alm_full_o, alm_empty_o, usage_o,
           overflow_o, underflow_o
  );

  // Producer/consumer side
  modport master (
    output flush_i, testmode_i, alm_full_th_i, alm_empty_th_i, clr_err_i,
           data_i, push_i, pop_i,
    input  data_o, full_o, empty_o, alm_full_o, alm_empty_o, usage_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, fill level and sticky error flags.
// Latency: 1 cycle push-to-data_o; 0 cycles into an empty FIFO when FALL_THROUGH=1.
// Backpressure: pushes while full are dropped (overflow_o), pops with nothing available are ignored (underflow_o).
module fifo_thresh #(
  parameter logic FALL_THROUGH = 1'b0,
  parameter int   DATA_WIDTH   = 32,
  parameter int   DEPTH        = 8,
  parameter int   CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fifo_thresh_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      usage_q, usage_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full, empty;
  logic push_ok, pop_ok, bypass, mem_we;
  logic unused_ok;

  // Clock-gating bypass has no functional role here.
  assign unused_ok = bus.testmode_i;

  // Flags come from registered occupancy only, so push/pop never reach them combinationally.
  assign full    = (usage_q == DEPTH_C);
  assign empty   = (usage_q == '0);
  assign push_ok = bus.push_i & ~full;
  assign pop_ok  = bus.pop_i & (~empty | (FALL_THROUGH & bus.push_i));
  // Empty fall-through with simultaneous push/pop: data goes straight through, nothing stored.
  assign bypass  = FALL_THROUGH & empty & bus.push_i & bus.pop_i;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers, occupancy, write enable and sticky error flags.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    mem_we   = 1'b0;
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      mem_we  = push_ok & ~bypass;
      usage_d = usage_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
    // A set event in the same cycle as clr_err_i wins; a push discarded by flush is not an overflow.
    ovf_d = (bus.push_i & full & ~bus.flush_i) | (ovf_q & ~bus.clr_err_i);
    udf_d = (bus.pop_i & ~pop_ok)              | (udf_q & ~bus.clr_err_i);
  end

  // State registers; reset overrides flush and error clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage; cleared on reset so an empty FIFO reads 0 until first write. Flush leaves contents alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.data_o      = (FALL_THROUGH & empty) ? bus.data_i : mem_q[rd_ptr_q];
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.usage_o     = usage_q;
  assign bus.alm_full_o  = (usage_q >= bus.alm_full_th_i);
  assign bus.alm_empty_o = (usage_q <= bus.alm_empty_th_i);
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: DEPTH=8/no fall-through and DEPTH=5/fall-through driven in lockstep.
// Latency: outputs sampled at the falling edge against a list-based occupancy model.
// Backpressure: overflow/underflow behaviour exercised by directed and random stimulus.
module tb_fifo_thresh;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, testmode, clr, push, pop;
  logic [31:0] din;
  logic [3:0]  afth, aeth;

  fifo_thresh_if #(.DATA_WIDTH(32), .DEPTH(8)) if8 ();
  fifo_thresh_if #(.DATA_WIDTH(32), .DEPTH(5)) if5 ();

  assign if8.flush_i        = flush;
  assign if8.testmode_i     = testmode;
  assign if8.alm_full_th_i  = afth;
  assign if8.alm_empty_th_i = aeth;
  assign if8.clr_err_i      = clr;
  assign if8.data_i         = din;
  assign if8.push_i         = push;
  assign if8.pop_i          = pop;
  assign if5.flush_i        = flush;
  assign if5.testmode_i     = testmode;
  assign if5.alm_full_th_i  = afth[2:0];
  assign if5.alm_empty_th_i = aeth[2:0];
  assign if5.clr_err_i      = clr;
  assign if5.data_i         = din;
  assign if5.push_i         = push;
  assign if5.pop_i          = pop;

  fifo_thresh #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(8)) u_d8 (
    .clk_i(clk), .rst_i(rst), .bus(if8.slave));
  fifo_thresh #(.FALL_THROUGH(1'b1), .DATA_WIDTH(32), .DEPTH(5)) u_d5 (
    .clk_i(clk), .rst_i(rst), .bus(if5.slave));

  // Reference model: per instance an ordered list (head at index 0) plus flags.
  int          dep [2] = '{8, 5};
  bit          ftv [2] = '{1'b0, 1'b1};
  int          mc  [2];
  logic [31:0] ml  [2][8];
  bit          mov [2], mud [2], mclean [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit full_s, empty_s, pok, qok, sov, sud;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mc[k] = 0; mov[k] = 0; mud[k] = 0; mclean[k] = 1;
      end else begin
        full_s  = (mc[k] == dep[k]);
        empty_s = (mc[k] == 0);
        pok = push && !full_s;
        qok = pop && (!empty_s || (ftv[k] && push));
        sov = push && full_s && !flush;
        sud = pop && !qok;
        if (flush) begin
          mc[k] = 0;
        end else if (!(pok && qok && empty_s)) begin
          if (qok) begin
            for (int i = 0; i < 7; i++) ml[k][i] = ml[k][i+1];
            mc[k]--;
          end
          if (pok) begin
            ml[k][mc[k]] = din;
            mc[k]++;
            mclean[k] = 0;
          end
        end
        mov[k] = sov ? 1'b1 : (clr ? 1'b0 : mov[k]);
        mud[k] = sud ? 1'b1 : (clr ? 1'b0 : mud[k]);
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic [3:0]  u, thf, the;
    logic        f, e, af, ae, ov, ud;
    logic [31:0] d;
    string       p;
    p = (k == 0) ? "d8" : "d5";
    if (k == 0) begin
      u = if8.usage_o; f = if8.full_o; e = if8.empty_o; af = if8.alm_full_o;
      ae = if8.alm_empty_o; ov = if8.overflow_o; ud = if8.underflow_o; d = if8.data_o;
      thf = afth; the = aeth;
    end else begin
      u = {1'b0, if5.usage_o}; f = if5.full_o; e = if5.empty_o; af = if5.alm_full_o;
      ae = if5.alm_empty_o; ov = if5.overflow_o; ud = if5.underflow_o; d = if5.data_o;
      thf = {1'b0, afth[2:0]}; the = {1'b0, aeth[2:0]};
    end
    chk({p, "_usage"},     32'(u),  32'(mc[k]));
    chk({p, "_full"},      32'(f),  32'(mc[k] == dep[k]));
    chk({p, "_empty"},     32'(e),  32'(mc[k] == 0));
    chk({p, "_alm_full"},  32'(af), 32'(mc[k] >= int'(thf)));
    chk({p, "_alm_empty"}, 32'(ae), 32'(mc[k] <= int'(the)));
    chk({p, "_overflow"},  32'(ov), 32'(mov[k]));
    chk({p, "_underflow"}, 32'(ud), 32'(mud[k]));
    if (ftv[k] && mc[k] == 0)  chk({p, "_data_ft"},    d, din);
    else if (mc[k] > 0)        chk({p, "_data_head"},  d, ml[k][0]);
    else if (mclean[k])        chk({p, "_data_reset"}, d, 32'h0);
  endtask

  // Inputs are set just after a rising edge; outputs checked at the falling edge; model steps at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; flush = 0; clr = 0; rst = 0;
  endtask

  initial begin
    rst = 1; flush = 0; testmode = 0; clr = 0; push = 0; pop = 0;
    din = 32'h1234_5678; afth = 4'd6; aeth = 4'd2;
    for (int k = 0; k < 2; k++) begin mc[k] = 0; mov[k] = 0; mud[k] = 0; mclean[k] = 1; end
    @(posedge clk); model_edge(); #1;
    tick();
    idle();
    tick();

    // Fill with 0x11..0x88, then drain in order.
    for (int i = 1; i <= 8; i++) begin push = 1; din = 32'h11 * i; tick(); end
    push = 0;
    chk("fill_usage8", 32'(if8.usage_o), 32'd8);
    chk("fill_full",   32'(if8.full_o),  32'd1);
    for (int i = 0; i < 8; i++) begin pop = 1; tick(); end
    pop = 0; tick();

    // Push+pop while full drops the push and sets overflow; clr_err clears it.
    for (int i = 0; i < 8; i++) begin push = 1; din = $urandom; tick(); end
    pop = 1; din = 32'hDEAD_BEEF; tick();
    idle();
    chk("ovf_usage7", 32'(if8.usage_o),    32'd7);
    chk("ovf_flag",   32'(if8.overflow_o), 32'd1);
    clr = 1; tick(); clr = 0;
    chk("ovf_cleared", 32'(if8.overflow_o), 32'd0);

    // Drain past empty: underflow without fall-through.
    for (int i = 0; i < 9; i++) begin pop = 1; tick(); end
    pop = 0;
    chk("udf_flag",  32'(if8.underflow_o), 32'd1);
    chk("udf_usage", 32'(if8.usage_o),     32'd0);
    clr = 1; tick(); clr = 0;

    // Fall-through bypass on the empty DEPTH=5 instance.
    push = 1; pop = 1; din = 32'hAB;
    #2 chk("ft_bypass_data", if5.data_o, 32'hAB);
    tick();
    idle();
    chk("ft_no_udf", 32'(if5.underflow_o), 32'd0);
    chk("ft_usage0", 32'(if5.usage_o),     32'd0);
    clr = 1; tick(); clr = 0;

    // Threshold sweep 0..8, then raise almost-full threshold above DEPTH.
    afth = 4'd6; aeth = 4'd2;
    for (int i = 0; i < 8; i++) begin push = 1; din = $urandom; tick(); end
    push = 0;
    afth = 4'd9; #1;
    chk("th_above_depth", 32'(if8.alm_full_o), 32'd0);
    tick();
    afth = 4'd6;

    // Flush at usage 5 together with a push.
    for (int i = 0; i < 3; i++) begin pop = 1; tick(); end
    pop = 0; flush = 1; push = 1; din = 32'h5555; tick();
    idle();
    chk("flush_usage", 32'(if8.usage_o), 32'd0);
    chk("flush_empty", 32'(if8.empty_o), 32'd1);
    tick();

    // Usage held at 3 with simultaneous push/pop; exercises DEPTH=5 wrap.
    for (int i = 0; i < 3; i++) begin push = 1; din = $urandom; tick(); end
    for (int i = 0; i < 20; i++) begin push = 1; pop = 1; din = $urandom; tick(); end
    idle();
    chk("wrap_usage3", 32'(if5.usage_o), 32'd3);
    tick();

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) begin push = 1; pop = (i % 2); din = $urandom; tick(); end
    rst = 1; tick();
    idle(); tick();
    chk("rst_usage", 32'(if8.usage_o), 32'd0);
    chk("rst_data",  if8.data_o,       32'd0);

    // Randomized traffic with varying push/pop bias, flushes, clears, resets and threshold changes.
    for (int c = 0; c < 1500; c++) begin
      int pb, qb;
      pb = (c / 300 == 1) ? 80 : (c / 300 == 3) ? 25 : 55;
      qb = (c / 300 == 1) ? 30 : (c / 300 == 3) ? 75 : 50;
      push  = ($urandom_range(0, 99) < pb);
      pop   = ($urandom_range(0, 99) < qb);
      din   = $urandom;
      flush = ($urandom_range(0, 49) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) begin
        afth = 4'($urandom_range(0, 10));
        aeth = 4'($urandom_range(0, 10));
      end
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
